imsic_intp_file: RTL and testbench
==================================

Name: imsic_intp_file

Overview:
Single IMSIC interrupt file: holds eip/eie bit arrays for NrSources identities, accepts MSI writes from the AIA bus slave, and serves 64-bit indirect CSR word accesses. A sequential priority scanner produces topei for the hart CSR file, which sits directly downstream and consumes topei_o/irq_o. Instantiated 2 + NrVSIntpFiles times per hart: M, S and each VS file.

Parameters:
NrSources, 256, number of identities; multiple of 64, range 64..2048; identity 0 is reserved.
IdW, $clog2(NrSources), identity width.
NW, NrSources/64, number of 64-bit eip/eie words (derived, not overridable).

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
msi_valid_i  in  1  MSI write strobe, single cycle, no backpressure
msi_id_i  in  IdW+1  MSI identity, extra bit to detect out-of-range
csr_req_i  in  1  CSR word access strobe
csr_we_i  in  1  1 = write, 0 = read
csr_sel_i  in  1  0 = eip array, 1 = eie array
csr_idx_i  in  6  word index, 0..NW-1
csr_wdata_i  in  64  write data
csr_rdata_o  out  64  read data, registered
eidelivery_i  in  1  delivery enable
eithreshold_i  in  IdW  priority threshold; 0 = disabled
claim_i  in  1  topei claim, single-cycle strobe from CSR file
topei_o  out  IdW  current top pending-enabled identity; 0 = none
irq_o  out  1  interrupt request to hart

Behaviour:
- One clock, synchronous active-high reset; all state updates on the clk_i rising edge.
- Reset: eip = 0, eie = 0, topei_o = 0, irq_o = 0 (combinational from topei_o), csr_rdata_o = 0, scan pointer = 0, running best = 0.
- Bit 0 of eip/eie word 0 is hardwired 0: writes ignored, reads return 0.
- MSI: if msi_valid_i and 0 < msi_id_i < NrSources, set eip[msi_id_i] next cycle. Id 0 or id >= NrSources is silently dropped.
- CSR write: replace word csr_idx_i of the selected array with csr_wdata_i. csr_idx_i >= NW: write ignored.
- CSR read: csr_rdata_o = selected word one cycle after csr_req_i; csr_idx_i >= NW reads 0. csr_rdata_o holds its value when no request is present.
- Same-cycle priority on eip, applied in this order: CSR write, then claim clear, then MSI set (OR). An MSI therefore always survives.
- Scanner: free-running, one word per cycle.
  - ptr counts 0..NW-1 and wraps.
  - Candidate in word w = lowest set bit of (eip[w] & eie[w]) that passes the threshold filter, giving id = w*64 + bit.
  - Threshold filter: eithreshold_i == 0, or id < eithreshold_i.
  - best latches the first valid candidate of the pass; the ascending scan guarantees the minimum id wins.
  - At ptr == NW-1: topei_o <= best (or the current candidate if best is 0); best <= 0; ptr <= 0.
  - NW == 1: commit every cycle.
- Update latency: an eip/eie change is reflected in topei_o within 2*NW cycles. No pass restart on MSI or CSR writes.
- Claim:
  - eip[topei_o] clears (unless an MSI to the same id arrives the same cycle).
  - topei_o <= 0 next cycle.
  - ptr <= 0 and best <= 0, so the pass restarts and a stale id is never committed.
  - Claim while topei_o == 0: no eip change, pass still restarts.
- irq_o = eidelivery_i & (topei_o != 0).
- Reset asserted mid-pass: everything returns to reset values in the next cycle.

Optional Feature:
IMSIC_DUAL_SCAN_EN
- Defined: scanner evaluates words 2k and 2k+1 per cycle, lower word taking precedence. Pass length is ceil(NW/2) cycles, latency bound becomes 2*ceil(NW/2), and commit happens on the last pair. For odd NW the upper lane is treated as zero.
- Undefined: single-word scan as above.
- Claim, MSI and CSR semantics are identical in both modes.

Test Plan:
- Reset with NrSources=256 -> topei_o=0, irq_o=0; CSR read of eip and eie idx 0..3 returns 0; read of idx 5 returns 0.
- CSR write eie[0]=64'hFFFF_FFFF_FFFF_FFFF, MSI id 5, eidelivery_i=1 -> topei_o=5 and irq_o=1 within 8 cycles; eip[0] reads 64'h20.
- Enable all, MSIs 200 and 5 -> topei_o=5; claim -> topei_o=0 next cycle, eip bit 5 clear, topei_o=200 within 8 cycles.
- Pending and enabled id 150, eithreshold_i=100 -> topei_o stays 0 for 16 cycles; set threshold to 0 -> topei_o=150 within 8 cycles.
- MSI id 0 and MSI id 300 -> eip reads all zero and topei_o=0; CSR write eip[0]=1 -> reads back 0 (bit 0 hardwired).
- Claim of id 5 with an MSI to id 5 in the same cycle -> eip bit 5 stays 1, topei_o=0 for one cycle, then 5 within 8 cycles. Repeat with IMSIC_DUAL_SCAN_EN defined -> bound 4 cycles.

Source files
------------

// File: rtl/imsic_intp_file.sv
// IMSIC interrupt file: eip/eie arrays, MSI set path, 64-bit CSR word access and topei scanner.
// Define IMSIC_DUAL_SCAN_EN to evaluate two words per scan cycle; the default build scans one.
module imsic_intp_file #(
    parameter int NrSources = 256,
    parameter int IdW       = $clog2(NrSources)
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           msi_valid_i,
    input  logic [IdW:0]   msi_id_i,
    input  logic           csr_req_i,
    input  logic           csr_we_i,
    input  logic           csr_sel_i,
    input  logic [5:0]     csr_idx_i,
    input  logic [63:0]    csr_wdata_i,
    output logic [63:0]    csr_rdata_o,
    input  logic           eidelivery_i,
    input  logic [IdW-1:0] eithreshold_i,
    input  logic           claim_i,
    output logic [IdW-1:0] topei_o,
    output logic           irq_o
);

    localparam int NW = NrSources / 64;
`ifdef IMSIC_DUAL_SCAN_EN
    localparam int LANES = 2;
`else
    localparam int LANES = 1;
`endif
    localparam int NP = (NW + LANES - 1) / LANES;
    localparam int PW = (NP > 1) ? $clog2(NP) : 1;
    localparam logic [IdW:0]  ID_LIMIT = (IdW + 1)'(NrSources);
    localparam logic [PW-1:0] PTR_LAST = PW'(NP - 1);

    logic [63:0]    eip_reg  [NW];
    logic [63:0]    eip_next [NW];
    logic [63:0]    eie_reg  [NW];
    logic [63:0]    eie_next [NW];
    logic [63:0]    csr_rdata_reg;
    logic [63:0]    csr_rdata_next;
    logic [PW-1:0]  ptr_reg;
    logic [IdW-1:0] best_reg;
    logic [IdW-1:0] topei_reg;

    logic           msi_ok;
    logic           csr_wr;
    logic           claim_hit;
    logic           cand_valid;
    logic [IdW-1:0] cand_id;
    logic           lane_valid [LANES];
    logic [IdW-1:0] lane_id    [LANES];

    assign msi_ok    = msi_valid_i && (msi_id_i != '0) && (msi_id_i < ID_LIMIT);
    assign csr_wr    = csr_req_i && csr_we_i;
    assign claim_hit = claim_i && (topei_reg != '0);

    genvar gi;

    // Per-word next state: CSR write replaces the word, claim clears, MSI sets last so it always survives.
    for (gi = 0; gi < NW; gi++) begin : g_word
        localparam logic [63:0] KEEP_MASK = (gi == 0) ? ~64'd1 : ~64'd0;
        logic [63:0] eip_nx;
        logic [63:0] eie_nx;
        logic        word_sel;

        assign word_sel = (csr_idx_i == 6'(gi));

        always_comb begin
            eip_nx = eip_reg[gi];
            eie_nx = eie_reg[gi];
            if (csr_wr && word_sel) begin
                if (csr_sel_i)
                    eie_nx = csr_wdata_i;
                else
                    eip_nx = csr_wdata_i;
            end
            if (claim_hit && ((topei_reg >> 6) == IdW'(gi)))
                eip_nx[topei_reg[5:0]] = 1'b0;
            if (msi_ok && ((msi_id_i >> 6) == (IdW + 1)'(gi)))
                eip_nx[msi_id_i[5:0]] = 1'b1;
        end

        assign eip_next[gi] = eip_nx & KEEP_MASK;
        assign eie_next[gi] = eie_nx & KEEP_MASK;
    end

    always_comb begin
        csr_rdata_next = csr_rdata_reg;
        if (csr_req_i && !csr_we_i) begin
            csr_rdata_next = '0;
            for (int w = 0; w < NW; w++) begin
                if (csr_idx_i == 6'(w))
                    csr_rdata_next = csr_sel_i ? eie_reg[w] : eip_reg[w];
            end
        end
    end

    // Each lane finds the lowest pending-enabled id of its word that passes the threshold.
    for (gi = 0; gi < LANES; gi++) begin : g_lane
        logic [63:0]    word_bits;
        logic           lv;
        logic [IdW-1:0] lid;
        int             word_idx;

        always_comb begin
            word_idx  = int'(ptr_reg) * LANES + gi;
            word_bits = '0;
            for (int w = 0; w < NW; w++) begin
                if (word_idx == w)
                    word_bits = eip_reg[w] & eie_reg[w];
            end
            lv  = 1'b0;
            lid = '0;
            for (int b = 63; b >= 0; b--) begin
                if (word_bits[b] &&
                    ((eithreshold_i == '0) || ((word_idx * 64 + b) < int'(eithreshold_i)))) begin
                    lv  = 1'b1;
                    lid = IdW'(word_idx * 64 + b);
                end
            end
        end

        assign lane_valid[gi] = lv;
        assign lane_id[gi]    = lid;
    end

    // The lower word of a pair holds the smaller ids, so it takes precedence.
    always_comb begin
        cand_valid = 1'b0;
        cand_id    = '0;
        for (int l = LANES - 1; l >= 0; l--) begin
            if (lane_valid[l]) begin
                cand_valid = 1'b1;
                cand_id    = lane_id[l];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int w = 0; w < NW; w++) begin
                eip_reg[w] <= '0;
                eie_reg[w] <= '0;
            end
            csr_rdata_reg <= '0;
        end else begin
            eip_reg       <= eip_next;
            eie_reg       <= eie_next;
            csr_rdata_reg <= csr_rdata_next;
        end
    end

    // A claim restarts the pass so an id scanned before the clear is never committed.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_reg   <= '0;
            best_reg  <= '0;
            topei_reg <= '0;
        end else if (claim_i) begin
            ptr_reg   <= '0;
            best_reg  <= '0;
            topei_reg <= '0;
        end else if (ptr_reg == PTR_LAST) begin
            topei_reg <= (best_reg != '0) ? best_reg : cand_id;
            best_reg  <= '0;
            ptr_reg   <= '0;
        end else begin
            if ((best_reg == '0) && cand_valid)
                best_reg <= cand_id;
            ptr_reg <= ptr_reg + 1'b1;
        end
    end

    assign csr_rdata_o = csr_rdata_reg;
    assign topei_o     = topei_reg;
    assign irq_o       = eidelivery_i && (topei_reg != '0);

endmodule

// File: tb/tb_imsic_intp_file.sv
// Randomized bench for imsic_intp_file with an array-based reference model of eip/eie and topei.
module tb_imsic_intp_file;

    localparam int NS  = 256;
    localparam int IDW = $clog2(NS);
    localparam int NW  = NS / 64;
`ifdef IMSIC_DUAL_SCAN_EN
    localparam int LAT = 2 * ((NW + 1) / 2);
`else
    localparam int LAT = 2 * NW;
`endif

    logic           clk = 1'b0;
    logic           rst;
    logic           msi_valid;
    logic [IDW:0]   msi_id;
    logic           csr_req;
    logic           csr_we;
    logic           csr_sel;
    logic [5:0]     csr_idx;
    logic [63:0]    csr_wdata;
    logic [63:0]    csr_rdata;
    logic           eidelivery;
    logic [IDW-1:0] eithreshold;
    logic           claim;
    logic [IDW-1:0] topei;
    logic           irq;

    imsic_intp_file #(.NrSources(NS)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .msi_valid_i  (msi_valid),
        .msi_id_i     (msi_id),
        .csr_req_i    (csr_req),
        .csr_we_i     (csr_we),
        .csr_sel_i    (csr_sel),
        .csr_idx_i    (csr_idx),
        .csr_wdata_i  (csr_wdata),
        .csr_rdata_o  (csr_rdata),
        .eidelivery_i (eidelivery),
        .eithreshold_i(eithreshold),
        .claim_i      (claim),
        .topei_o      (topei),
        .irq_o        (irq)
    );

    always #5 clk = ~clk;

    bit [63:0] m_eip [NW];
    bit [63:0] m_eie [NW];
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void model_clear();
        for (int w = 0; w < NW; w++) begin
            m_eip[w] = '0;
            m_eie[w] = '0;
        end
    endfunction

    function automatic void model_set(input int id);
        if (id > 0 && id < NS)
            m_eip[id / 64][id % 64] = 1'b1;
    endfunction

    // Smallest pending, enabled id admitted by the threshold; 0 when none.
    function automatic int model_top();
        for (int i = 1; i < NS; i++) begin
            if (m_eip[i / 64][i % 64] && m_eie[i / 64][i % 64] &&
                (eithreshold == '0 || i < int'(eithreshold)))
                return i;
        end
        return 0;
    endfunction

    function automatic logic [63:0] sparse_word();
        logic [31:0] hi;
        logic [31:0] lo;
        hi = $urandom & $urandom & $urandom;
        lo = $urandom & $urandom & $urandom;
        return {hi, lo};
    endfunction

    task automatic idle_inputs();
        msi_valid = 1'b0;
        msi_id    = '0;
        csr_req   = 1'b0;
        csr_we    = 1'b0;
        csr_sel   = 1'b0;
        csr_idx   = '0;
        csr_wdata = '0;
        claim     = 1'b0;
    endtask

    task automatic send_msi(input int id);
        msi_valid = 1'b1;
        msi_id    = (IDW + 1)'(id);
        tick();
        msi_valid = 1'b0;
        model_set(id);
    endtask

    task automatic csr_write(input int sel, input int idx, input logic [63:0] data);
        csr_req   = 1'b1;
        csr_we    = 1'b1;
        csr_sel   = 1'(sel);
        csr_idx   = 6'(idx);
        csr_wdata = data;
        tick();
        csr_req = 1'b0;
        csr_we  = 1'b0;
        if (idx < NW) begin
            if (sel != 0)
                m_eie[idx] = data;
            else
                m_eip[idx] = data;
        end
        m_eip[0][0] = 1'b0;
        m_eie[0][0] = 1'b0;
    endtask

    task automatic csr_read(input int sel, input int idx, input string tag);
        logic [63:0] exp;
        csr_req = 1'b1;
        csr_we  = 1'b0;
        csr_sel = 1'(sel);
        csr_idx = 6'(idx);
        tick();
        csr_req = 1'b0;
        exp = '0;
        if (idx < NW)
            exp = (sel != 0) ? m_eie[idx] : m_eip[idx];
        check(tag, csr_rdata, exp);
    endtask

    task automatic settle(input string tag);
        int t;
        repeat (LAT) tick();
        t = model_top();
        check({tag, "_topei"}, 64'(topei), 64'(t));
        check({tag, "_irq"}, 64'(irq), 64'(eidelivery && (t != 0)));
    endtask

    // Claim the current top (model value, valid after settle); optional same-cycle MSI when msi >= 0.
    task automatic do_claim(input int msi, input string tag);
        int t;
        t = model_top();
        claim = 1'b1;
        if (msi >= 0) begin
            msi_valid = 1'b1;
            msi_id    = (IDW + 1)'(msi);
        end
        tick();
        claim     = 1'b0;
        msi_valid = 1'b0;
        if (t != 0)
            m_eip[t / 64][t % 64] = 1'b0;
        if (msi >= 0)
            model_set(msi);
        check({tag, "_zero"}, 64'(topei), 64'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [63:0] d;
        idle_inputs();
        rst         = 1'b1;
        eidelivery  = 1'b1;
        eithreshold = '0;
        model_clear();
        repeat (3) tick();
        rst = 1'b0;

        check("rst_topei", 64'(topei), 64'd0);
        check("rst_irq", 64'(irq), 64'd0);
        check("rst_rdata", csr_rdata, 64'd0);
        for (int w = 0; w < NW; w++) begin
            csr_read(0, w, $sformatf("rst_eip%0d", w));
            csr_read(1, w, $sformatf("rst_eie%0d", w));
        end
        csr_read(0, 5, "rst_eip_idx5");

        csr_write(1, 0, '1);
        send_msi(5);
        settle("msi5");
        check("msi5_const", 64'(topei), 64'd5);
        csr_read(0, 0, "msi5_eip0");
        check("eip0_const", csr_rdata, 64'h20);
        tick();
        check("rdata_hold", csr_rdata, 64'h20);

        for (int w = 1; w < NW; w++)
            csr_write(1, w, '1);
        send_msi(200);
        send_msi(5);
        settle("two_msi");
        do_claim(-1, "claim5");
        csr_read(0, 0, "claim5_eip0");
        settle("after_claim");
        check("after_claim_const", 64'(topei), 64'd200);

        for (int w = 0; w < NW; w++)
            csr_write(0, w, '0);
        eithreshold = IDW'(100);
        settle("thr_clear");
        send_msi(150);
        for (int c = 0; c < 16; c++)
            check($sformatf("thr_block_c%0d", c), 64'(topei), 64'd0);
        eithreshold = '0;
        settle("thr_off");

        for (int w = 0; w < NW; w++)
            csr_write(0, w, '0);
        send_msi(0);
        send_msi(300);
        for (int w = 0; w < NW; w++)
            csr_read(0, w, $sformatf("drop_eip%0d", w));
        settle("drop");
        csr_write(0, 0, 64'd1);
        csr_read(0, 0, "bit0_hw");

        send_msi(5);
        settle("reclaim_pre");
        do_claim(5, "claim_msi5");
        csr_read(0, 0, "claim_msi5_eip0");
        settle("claim_msi5_top");

        for (int i = 0; i < 80; i++) begin
            case ($urandom_range(0, 5))
                0, 1: send_msi(int'($urandom_range(0, 319)));
                2: begin
                    if ($urandom_range(0, 1) != 0) begin
                        d = ($urandom_range(0, 1) != 0) ? '1 : {$urandom, $urandom};
                        csr_write(1, int'($urandom_range(0, NW)), d);
                    end else begin
                        csr_write(0, int'($urandom_range(0, NW)), sparse_word());
                    end
                end
                3: csr_read(int'($urandom_range(0, 1)), int'($urandom_range(0, 7)), "rnd_rd");
                4: begin
                    settle("rnd_pre_claim");
                    do_claim(($urandom_range(0, 1) != 0) ? int'($urandom_range(1, NS - 1)) : -1,
                             "rnd_claim");
                end
                default: begin
                    eithreshold = ($urandom_range(0, 1) != 0) ? '0 : IDW'($urandom_range(1, NS - 1));
                    eidelivery  = 1'($urandom_range(0, 1));
                end
            endcase
            if (i % 5 == 4)
                settle("rnd_top");
        end

        eithreshold = '0;
        eidelivery  = 1'b1;
        csr_write(1, 0, '1);
        send_msi(7);
        settle("pre_reset");
        csr_read(0, 0, "pre_reset_rd");
        send_msi(9);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_clear();
        check("midrst_topei", 64'(topei), 64'd0);
        check("midrst_irq", 64'(irq), 64'd0);
        check("midrst_rdata", csr_rdata, 64'd0);
        for (int w = 0; w < NW; w++) begin
            csr_read(0, w, $sformatf("midrst_eip%0d", w));
            csr_read(1, w, $sformatf("midrst_eie%0d", w));
        end
        settle("midrst_idle");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
